// File: rtl/vx_commit_arbiter_pkg.sv
// Shared commit-path types for the execute-to-writeback merge.
// Packet layout and lane popcount helper.
package VX_gpu_pkg;

  localparam int NUM_EX_UNITS = 4;
  localparam int NUM_LANES    = 4;
  localparam int NUM_WARPS    = 4;
  localparam int XLEN         = 32;
  localparam int NR_BITS      = 6;
  localparam int PC_BITS      = 32;

  localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int UID_W = $clog2(NUM_EX_UNITS);
  localparam int CNT_W = $clog2(NUM_LANES) + 1;

  typedef struct packed {
    logic [WID_W-1:0]               wid;
    logic [NUM_LANES-1:0]           tmask;
    logic [PC_BITS-1:0]             PC;
    logic                           wb;
    logic [NR_BITS-1:0]             rd;
    logic [NUM_LANES-1:0][XLEN-1:0] data;
    logic                           sop;
    logic                           eop;
  } commit_data_t;

  localparam int CD_W = $bits(commit_data_t);

  function automatic logic [CNT_W-1:0] popcount(
    input logic [NUM_LANES-1:0] m
  );
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      c = c + CNT_W'(m[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/vx_commit_arbiter_rr_lock.sv
// Round-robin grant with a packet lock.
// Pointer moves past the winner only when a packet ends.
module vx_rr_lock_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_i,
  input  logic             lock_i,
  input  logic [IDX_W-1:0] lock_unit_i,
  input  logic             advance_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W:0]   s;

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    s       = '0;
    if (lock_i) begin
      idx_o   = lock_unit_i;
      valid_o = req_i[lock_unit_i];
    end else begin
      // Walk backwards so the smallest offset from ptr wins.
      for (int k = N - 1; k >= 0; k--) begin
        s = {1'b0, ptr_q} + (IDX_W+1)'(k);
        if (s >= (IDX_W+1)'(N)) begin
          s = s - (IDX_W+1)'(N);
        end
        if (req_i[s[IDX_W-1:0]]) begin
          idx_o   = s[IDX_W-1:0];
          valid_o = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_o = '0;
    if (valid_o) begin
      grant_o[idx_o] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (idx_o == IDX_W'(N - 1)) ? '0 : idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/vx_commit_arbiter.sv
// Merges execute-unit commit streams into one writeback stream
// and counts retired thread-instructions.
module vx_commit_arbiter
  import VX_gpu_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic         [NUM_EX_UNITS-1:0]  in_valid,
  output logic         [NUM_EX_UNITS-1:0]  in_ready,
  input  commit_data_t [NUM_EX_UNITS-1:0]  in_data,
  output logic                             wb_valid,
  input  logic                             wb_ready,
  output commit_data_t                     wb_data,
  output logic         [UID_W-1:0]         wb_unit,
  output logic                             retire_valid,
  output logic         [CNT_W-1:0]         retire_count,
  output logic         [63:0]              instret
);

  logic [NUM_EX_UNITS-1:0] grant;
  logic [UID_W-1:0]        gidx;
  logic                    gvalid;
  logic                    accept;
  logic                    fire;
  commit_data_t            sel;

  logic             lock_q, lock_d;
  logic [UID_W-1:0] lock_unit_q, lock_unit_d;

  logic             wb_valid_q, wb_valid_d;
  commit_data_t     wb_data_q, wb_data_d;
  logic [UID_W-1:0] wb_unit_q, wb_unit_d;

  logic             ret_q, ret_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      instret_q, instret_d;

  assign accept = ~wb_valid_q | wb_ready;
  assign sel    = in_data[gidx];
  assign fire   = gvalid & accept & reset_n;

  assign in_ready = (accept & reset_n) ? grant : '0;

  vx_rr_lock_arbiter #(
    .N (NUM_EX_UNITS)
  ) u_arb (
    .clk         (clk),
    .rst_n       (reset_n),
    .req_i       (in_valid),
    .lock_i      (lock_q),
    .lock_unit_i (lock_unit_q),
    .advance_i   (fire & sel.eop),
    .grant_o     (grant),
    .idx_o       (gidx),
    .valid_o     (gvalid)
  );

  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    wb_unit_d  = wb_unit_q;
    if (fire) begin
      wb_valid_d = 1'b1;
      wb_data_d  = sel;
      wb_unit_d  = gidx;
    end else if (wb_ready) begin
      wb_valid_d = 1'b0;
    end
  end

  // Retirement is booked at slot entry so wb stalls never lose it.
  always_comb begin
    lock_d      = lock_q;
    lock_unit_d = lock_unit_q;
    ret_d       = 1'b0;
    cnt_d       = '0;
    instret_d   = instret_q;
    if (fire) begin
      if (sel.eop) begin
        lock_d    = 1'b0;
        ret_d     = 1'b1;
        cnt_d     = popcount(sel.tmask);
        instret_d = instret_q + 64'(cnt_d);
      end else begin
        lock_d      = 1'b1;
        lock_unit_d = gidx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q      <= 1'b0;
      lock_unit_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_unit_q   <= '0;
      ret_q       <= 1'b0;
      cnt_q       <= '0;
      instret_q   <= '0;
    end else begin
      lock_q      <= lock_d;
      lock_unit_q <= lock_unit_d;
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_unit_q   <= wb_unit_d;
      ret_q       <= ret_d;
      cnt_q       <= cnt_d;
      instret_q   <= instret_d;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_data      = wb_data_q;
  assign wb_unit      = wb_unit_q;
  assign retire_valid = ret_q;
  assign retire_count = cnt_q;
  assign instret      = instret_q;

  a_sop_in_lock: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(fire && lock_q && sel.sop)
  );

  a_no_orphan: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(fire && !lock_q && !sel.sop)
  );

  for (genvar i = 0; i < NUM_EX_UNITS; i++) begin : g_stable
    a_hold: assert property (
      @(posedge clk) disable iff (!reset_n)
      in_valid[i] && !in_ready[i]
        |=> in_valid[i] && $stable(in_data[i])
    );
  end

endmodule

// File: tb/tb_vx_commit_arbiter.sv
// Directed plus random checks of the commit arbiter
// against a packet-level reference model.
module tb_vx_commit_arbiter;
  import VX_gpu_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b1;
  logic [3:0]             in_valid;
  logic [3:0]             in_ready;
  commit_data_t [3:0]     in_data;
  logic                   wb_valid;
  logic                   wb_ready;
  commit_data_t           wb_data;
  logic [UID_W-1:0]       wb_unit;
  logic                   retire_valid;
  logic [CNT_W-1:0]       retire_count;
  logic [63:0]            instret;

  vx_commit_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_data      (wb_data),
    .wb_unit      (wb_unit),
    .retire_valid (retire_valid),
    .retire_count (retire_count),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  commit_data_t q [4][$];
  bit   pres [4];
  int   pres_pct = 100;
  logic wbr = 1'b1;
  int   obs [$];
  bit   log_en = 1'b0;
  int   e2 [6] = '{0, 1, 2, 3, 0, 1};
  int   e3 [6] = '{2, 2, 2, 3, 0, 1};

  // Reference state: lock owner (-1 none), rr start, output slot.
  int           m_lock;
  int           m_ptr;
  bit           m_wv;
  commit_data_t m_wd;
  int           m_wu;
  bit           m_rv;
  int           m_rc;
  logic [63:0]  m_inst;

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic commit_data_t mk(logic [3:0] tm, bit s, bit e);
    commit_data_t p;
    p.wid   = WID_W'($urandom);
    p.tmask = tm;
    p.PC    = $urandom;
    p.wb    = 1'($urandom);
    p.rd    = NR_BITS'($urandom);
    for (int l = 0; l < NUM_LANES; l++) p.data[l] = $urandom;
    p.sop = s;
    p.eop = e;
    return p;
  endfunction

  task automatic burst(input int u, input int len);
    for (int k = 0; k < len; k++)
      q[u].push_back(mk(4'($urandom), k == 0, k == len - 1));
  endtask

  task automatic present();
    for (int u = 0; u < 4; u++)
      if (!pres[u] && q[u].size() > 0 &&
          $urandom_range(99) < pres_pct)
        pres[u] = 1'b1;
  endtask

  function automatic int mgrant();
    if (m_lock >= 0) return in_valid[m_lock] ? m_lock : -1;
    for (int k = 0; k < 4; k++) begin
      int u;
      u = (m_ptr + k) % 4;
      if (in_valid[u]) return u;
    end
    return -1;
  endfunction

  task automatic step();
    int g;
    bit acc;
    logic [3:0] er;
    commit_data_t p;
    for (int u = 0; u < 4; u++) begin
      in_valid[u] = pres[u];
      in_data[u]  = pres[u] ? q[u][0] : '0;
    end
    wb_ready = wbr;
    #1;
    g   = mgrant();
    acc = !m_wv || wbr;
    er  = (g >= 0 && acc) ? 4'(1 << g) : 4'b0;
    chk("in_ready", 256'(in_ready), 256'(er));
    @(posedge clk);
    m_rv = 0;
    m_rc = 0;
    if (er != 0) begin
      p = q[g].pop_front();
      pres[g] = 0;
      m_wv = 1;
      m_wd = p;
      m_wu = g;
      if (p.eop) begin
        m_lock = -1;
        m_ptr  = (g + 1) % 4;
        m_rv   = 1;
        m_rc   = $countones(p.tmask);
        m_inst += 64'(m_rc);
      end else begin
        m_lock = g;
      end
    end else if (m_wv && wbr) begin
      m_wv = 0;
    end
    #1;
    chk("wb_valid", 256'(wb_valid), 256'(m_wv));
    if (m_wv) begin
      chk("wb_data", 256'(wb_data), 256'(m_wd));
      chk("wb_unit", 256'(wb_unit), 256'(m_wu));
    end
    if (log_en && er != 0) obs.push_back(int'(wb_unit));
    chk("retire_valid", 256'(retire_valid), 256'(m_rv));
    chk("retire_count", 256'(retire_count), 256'(m_rc));
    chk("instret", 256'(instret), 256'(m_inst));
    present();
  endtask

  task automatic drain(input int maxc);
    int c;
    bit busy;
    c = 0;
    busy = 1;
    while (busy && c < maxc) begin
      busy = m_wv;
      for (int u = 0; u < 4; u++)
        if (q[u].size() > 0) busy = 1;
      if (busy) begin
        step();
        c++;
      end
    end
    chk("drain_budget", 256'(c < maxc), 256'(1));
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    in_valid = 4'hF;
    #1;
    chk("rst_wb_valid", 256'(wb_valid), 256'(0));
    chk("rst_wb_data", 256'(wb_data), 256'(0));
    chk("rst_wb_unit", 256'(wb_unit), 256'(0));
    chk("rst_retire_valid", 256'(retire_valid), 256'(0));
    chk("rst_retire_count", 256'(retire_count), 256'(0));
    chk("rst_instret", 256'(instret), 256'(0));
    chk("rst_in_ready", 256'(in_ready), 256'(0));
    m_lock = -1;
    m_ptr  = 0;
    m_wv   = 0;
    m_wd   = '0;
    m_wu   = 0;
    m_rv   = 0;
    m_rc   = 0;
    m_inst = '0;
    for (int u = 0; u < 4; u++) begin
      q[u].delete();
      pres[u] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    in_valid = '0;
    reset_n  = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = '0;
    in_data  = '0;
    wb_ready = 1'b1;
    #2;

    // Single packet, tmask 1011.
    do_reset();
    q[0].push_back(mk(4'b1011, 1, 1));
    present();
    step();
    chk("t1_wb_valid", 256'(wb_valid), 256'(1));
    chk("t1_wb_unit", 256'(wb_unit), 256'(0));
    chk("t1_retire_count", 256'(retire_count), 256'(3));
    chk("t1_instret", 256'(instret), 256'(3));
    drain(20);

    // All units valid: round-robin order.
    do_reset();
    burst(0, 1); burst(0, 1);
    burst(1, 1); burst(1, 1);
    burst(2, 1); burst(3, 1);
    present();
    obs.delete();
    log_en = 1;
    drain(30);
    log_en = 0;
    chk("t2_count", 256'(obs.size()), 256'(6));
    for (int i = 0; i < 6; i++)
      chk("t2_order", 256'(i < obs.size() ? obs[i] : -1), 256'(e2[i]));

    // Unit 2 burst is not interleaved.
    burst(2, 3);
    burst(0, 1); burst(1, 1); burst(3, 1);
    present();
    obs.delete();
    log_en = 1;
    drain(30);
    log_en = 0;
    chk("t3_count", 256'(obs.size()), 256'(6));
    for (int i = 0; i < 6; i++)
      chk("t3_order", 256'(i < obs.size() ? obs[i] : -1), 256'(e3[i]));

    // Writeback backpressure.
    wbr = 0;
    burst(0, 1); burst(1, 1); burst(1, 1);
    present();
    repeat (5) step();
    chk("t4_hold_ready", 256'(in_ready), 256'(0));
    chk("t4_hold_valid", 256'(wb_valid), 256'(1));
    wbr = 1;
    drain(30);

    // instret wraps modulo 2^64.
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFE;
    m_inst = 64'hFFFF_FFFF_FFFF_FFFE;
    @(negedge clk);
    release dut.instret_q;
    q[0].push_back(mk(4'b1111, 1, 1));
    present();
    step();
    chk("t5_wrap", 256'(instret), 256'(2));
    drain(20);

    // Reset while a burst holds the lock.
    burst(1, 3);
    burst(0, 1); burst(2, 1); burst(3, 1);
    present();
    step();
    step();
    do_reset();
    burst(0, 1); burst(1, 1); burst(2, 1); burst(3, 1);
    present();
    step();
    chk("t6_first_unit", 256'(wb_unit), 256'(0));
    drain(30);

    // Random traffic with random backpressure.
    pres_pct = 50;
    for (int c = 0; c < 400; c++) begin
      for (int u = 0; u < 4; u++)
        if ($urandom_range(3) == 0 && q[u].size() < 4)
          burst(u, int'($urandom_range(1, 3)));
      wbr = ($urandom_range(3) != 0);
      step();
    end
    wbr = 1;
    pres_pct = 100;
    present();
    drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
